// File: rtl/risc_fsm_pkg.sv
// Shared definitions for the multi-cycle RISC core: FSM state encoding,
// opcode values, instruction field positions and small decode helpers.
package risc_fsm_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
    ST_HALT      = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_LI   = 4'h8;
  localparam logic [3:0] OP_BEQZ = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS1_MSB = 8;
  localparam int RS1_LSB = 6;
  localparam int RS2_MSB = 5;
  localparam int RS2_LSB = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  function automatic logic is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  function automatic logic writes_rd(input logic [3:0] op);
    return is_alu(op) || (op == OP_LI);
  endfunction

endpackage

// File: rtl/regfile_p.sv
// Eight-entry register file: two asynchronous read ports, one synchronous
// write port; reset clears every entry.
module regfile_p #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [2:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs [0:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/risc_core_fsm.sv
// Multi-cycle RISC core: FETCH -> DECODE -> EXECUTE -> WRITEBACK, with a
// terminal HALT state left only through reset.
module risc_core_fsm
  import risc_fsm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [15:0]       imem_rdata,
  input  logic              imem_valid,
  output logic [15:0]       current_instruction,
  output logic [PC_W-1:0]   program_counter_out,
  output logic [DATA_W-1:0] results,
  output logic              zero_flag,
  output logic              halted,
  output logic [15:0]       retired
);

  state_t state_reg, state_next;

  logic [PC_W-1:0]   pc_reg;
  logic [15:0]       ir_reg;
  logic [DATA_W-1:0] a_reg, b_reg, results_reg;
  logic              zero_reg, taken_reg;
  logic [15:0]       retired_reg;

  logic [3:0]        opcode;
  logic [2:0]        rd, rs1, rs2;
  logic [7:0]        imm8;
  logic [DATA_W-1:0] imm_data, alu_res, rf_a, rf_b;
  logic [PC_W-1:0]   imm_pc;
  logic              rf_we;

  assign opcode   = ir_reg[OPC_MSB:OPC_LSB];
  assign rd       = ir_reg[RD_MSB:RD_LSB];
  assign rs1      = ir_reg[RS1_MSB:RS1_LSB];
  assign rs2      = ir_reg[RS2_MSB:RS2_LSB];
  assign imm8     = ir_reg[IMM_MSB:IMM_LSB];
  assign imm_data = DATA_W'(imm8);
  assign imm_pc   = PC_W'(imm8);

  // Write data comes from results, which EXECUTE has just loaded.
  assign rf_we = (state_reg == ST_WRITEBACK) && writes_rd(opcode) && !rst;

  regfile_p #(.DATA_W(DATA_W)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rd),
    .wdata   (results_reg),
    .raddr_a (rs1),
    .rdata_a (rf_a),
    .raddr_b (rs2),
    .rdata_b (rf_b)
  );

  always_comb begin
    alu_res = '0;
    case (opcode)
      OP_ADD:  alu_res = a_reg + b_reg;
      OP_SUB:  alu_res = a_reg - b_reg;
      OP_AND:  alu_res = a_reg & b_reg;
      OP_OR:   alu_res = a_reg | b_reg;
      OP_XOR:  alu_res = a_reg ^ b_reg;
      OP_SHL:  alu_res = {a_reg[DATA_W-2:0], 1'b0};
      OP_SHR:  alu_res = {1'b0, a_reg[DATA_W-1:1]};
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH:     if (imem_valid) state_next = ST_DECODE;
      ST_DECODE:    state_next = ST_EXECUTE;
      ST_EXECUTE:   state_next = ST_WRITEBACK;
      ST_WRITEBACK: state_next = (opcode == OP_HALT) ? ST_HALT : ST_FETCH;
      ST_HALT:      state_next = ST_HALT;
      default:      state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    imem_req = (state_reg == ST_FETCH);
    halted   = (state_reg == ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= '0;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      results_reg <= '0;
      zero_reg    <= 1'b0;
      taken_reg   <= 1'b0;
      retired_reg <= '0;
    end else begin
      case (state_reg)
        ST_FETCH: begin
          if (imem_valid) ir_reg <= imem_rdata;
        end
        ST_DECODE: begin
          a_reg <= rf_a;
          b_reg <= rf_b;
        end
        ST_EXECUTE: begin
          if (writes_rd(opcode)) begin
            results_reg <= (opcode == OP_LI) ? imm_data : alu_res;
          end
          if (is_alu(opcode)) zero_reg <= (alu_res == '0);
          taken_reg <= ((opcode == OP_BEQZ) && (a_reg == '0)) || (opcode == OP_JMP);
        end
        ST_WRITEBACK: begin
          // HALT keeps the PC pointing at itself.
          if (opcode != OP_HALT) pc_reg <= taken_reg ? imm_pc : pc_reg + 1'b1;
          if (retired_reg != 16'hFFFF) retired_reg <= retired_reg + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr           = pc_reg;
  assign program_counter_out = pc_reg;
  assign current_instruction = ir_reg;
  assign results             = results_reg;
  assign zero_flag           = zero_reg;
  assign retired             = retired_reg;

endmodule

// File: tb/tb_risc_core_fsm.sv
// Directed bench for risc_core_fsm: small programs in a bench memory, expected
// per-instruction outcomes queued up front and compared at each retirement.
module tb_risc_core_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] current_instruction;
  logic [7:0]  program_counter_out;
  logic [7:0]  results;
  logic        zero_flag;
  logic        halted;
  logic [15:0] retired;

  always #5 clk = ~clk;

  risc_core_fsm #(.DATA_W(8), .PC_W(8)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .imem_req            (imem_req),
    .imem_addr           (imem_addr),
    .imem_rdata          (imem_rdata),
    .imem_valid          (imem_valid),
    .current_instruction (current_instruction),
    .program_counter_out (program_counter_out),
    .results             (results),
    .zero_flag           (zero_flag),
    .halted              (halted),
    .retired             (retired)
  );

  // Instruction memory with a programmable fetch latency; noise raises
  // imem_valid while no fetch is pending, which the core must ignore.
  logic [15:0] imem [0:255];
  int          delay_cfg = 0;
  logic        noise = 1'b0;
  int          wait_cnt = 0;

  assign imem_rdata = imem[imem_addr];
  assign imem_valid = (imem_req && (wait_cnt >= delay_cfg)) || (noise && !imem_req);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_valid) wait_cnt <= 0;
    else                                wait_cnt <= wait_cnt + 1;
  end

  typedef struct {
    logic [15:0] ir;
    logic [7:0]  res;
    logic        z;
    logic [7:0]  pc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] ir, input logic [7:0] res, input logic z,
                      input logic [7:0] pc);
    exp_t e;
    e.ir = ir; e.res = res; e.z = z; e.pc = pc;
    sb.push_back(e);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_pc", program_counter_out, 0);
    chk("rst_ir", current_instruction, 0);
    chk("rst_results", results, 0);
    chk("rst_zero", zero_flag, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retired", retired, 0);
  endtask

  // Release reset and compare each retirement against the queue head,
  // including the cycle at which it retires (k * cycles-per-instruction).
  task automatic run(input int cpi);
    int   cycles;
    int   k;
    int   budget;
    logic [15:0] prev;
    exp_t e;
    rst = 1'b0;
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    cycles = 0;
    k      = 0;
    prev   = retired;
    budget = sb.size() * cpi + 20;
    while (sb.size() > 0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (retired != prev) begin
        prev = retired;
        k++;
        e = sb.pop_front();
        $display("retire %0d @cycle %0d: ir=%h results=%h zero=%0b pc=%h",
                 k, cycles, current_instruction, results, zero_flag, program_counter_out);
        chk("ir", current_instruction, e.ir);
        chk("results", results, e.res);
        chk("zero", zero_flag, e.z);
        chk("pc", program_counter_out, e.pc);
        chk("retired", retired, k);
        chk("cycle", cycles, k * cpi);
      end
    end
    if (sb.size() != 0) begin
      chk("retire_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic load_basic();
    clear_mem();
    imem[0] = 16'h8205;  // LI r1,5
    imem[1] = 16'h8403;  // LI r2,3
    imem[2] = 16'h1650;  // ADD r3,r1,r2
    imem[3] = 16'h4CC0;  // OR r6,r3,r0 (exposes r3)
    imem[4] = 16'hF000;  // HALT
    push(16'h8205, 8'h05, 1'b0, 8'h01);
    push(16'h8403, 8'h03, 1'b0, 8'h02);
    push(16'h1650, 8'h08, 1'b0, 8'h03);
    push(16'h4CC0, 8'h08, 1'b0, 8'h04);
    push(16'hF000, 8'h08, 1'b0, 8'h04);
  endtask

  task automatic check_halt(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      chk("halt_halted", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_pc", program_counter_out, 8'h04);
      chk("halt_retired", retired, 5);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Basic program, zero-wait memory, then HALT freeze
    apply_reset();
    load_basic();
    run(4);
    check_halt(20);

    // Arithmetic wrap and zero flag
    apply_reset();
    clear_mem();
    imem[0] = 16'h82FF;  // LI r1,0xFF
    imem[1] = 16'h8401;  // LI r2,1
    imem[2] = 16'h1650;  // ADD r3,r1,r2
    imem[3] = 16'h2810;  // SUB r4,r0,r2
    imem[4] = 16'hF000;
    push(16'h82FF, 8'hFF, 1'b0, 8'h01);
    push(16'h8401, 8'h01, 1'b0, 8'h02);
    push(16'h1650, 8'h00, 1'b1, 8'h03);
    push(16'h2810, 8'hFF, 1'b0, 8'h04);
    push(16'hF000, 8'hFF, 1'b0, 8'h04);
    run(4);

    // Branches and fall-through PC wrap
    apply_reset();
    clear_mem();
    imem[8'h00] = 16'h9020;  // BEQZ r0,0x20 (taken)
    imem[8'h20] = 16'h8201;  // LI r1,1
    imem[8'h21] = 16'h9040;  // BEQZ r1,0x40 (not taken)
    imem[8'h22] = 16'hA0FF;  // JMP 0xFF
    imem[8'hFF] = 16'h0000;  // NOP at top of memory
    push(16'h9020, 8'h00, 1'b0, 8'h20);
    push(16'h8201, 8'h01, 1'b0, 8'h21);
    push(16'h9040, 8'h01, 1'b0, 8'h22);
    push(16'hA0FF, 8'h01, 1'b0, 8'hFF);
    push(16'h0000, 8'h01, 1'b0, 8'h00);
    run(4);

    // JMP executed from 0xFF
    apply_reset();
    clear_mem();
    imem[8'h00] = 16'hA0FF;
    imem[8'hFF] = 16'hA000;
    push(16'hA0FF, 8'h00, 1'b0, 8'hFF);
    push(16'hA000, 8'h00, 1'b0, 8'h00);
    push(16'hA0FF, 8'h00, 1'b0, 8'hFF);
    run(4);

    // Same basic program with 3 wait cycles per fetch and stray valids
    apply_reset();
    delay_cfg = 3;
    noise     = 1'b1;
    load_basic();
    run(7);
    check_halt(5);
    delay_cfg = 0;
    noise     = 1'b0;

    // Reset during WRITEBACK of ADD r5
    apply_reset();
    clear_mem();
    imem[0] = 16'h8202;  // LI r1,2
    imem[1] = 16'h8403;  // LI r2,3
    imem[2] = 16'h1A50;  // ADD r5,r1,r2
    push(16'h8202, 8'h02, 1'b0, 8'h01);
    push(16'h8403, 8'h03, 1'b0, 8'h02);
    run(4);
    repeat (3) @(negedge clk);
    chk("wb_ir", current_instruction, 16'h1A50);
    chk("wb_results", results, 8'h05);
    chk("wb_retired", retired, 2);
    rst = 1'b1;
    @(negedge clk);
    chk("wbrst_retired", retired, 0);
    chk("wbrst_pc", program_counter_out, 0);
    chk("wbrst_results", results, 0);
    imem[0] = 16'h4D40;  // OR r6,r5,r0 (exposes r5)
    push(16'h4D40, 8'h00, 1'b1, 8'h01);
    run(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/risc_core_fsm.md
RISC_CORE_FSM -- requirements
Module: risc_core_fsm

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath and register width (4..32).
REQ-002 SHALL have parameter PC_W, default 8, program-counter and instruction-address width (4..16).
REQ-003 SHALL have ports clk (input, 1 bit), the single clock, with all state on its rising edge.
REQ-004 SHALL have port rst (input, 1 bit), a synchronous, active-high reset.
REQ-005 SHALL have port imem_req (output, 1 bit), the instruction-fetch request.
REQ-006 SHALL have port imem_addr (output, PC_W bits), the fetch address; it equals the PC.
REQ-007 SHALL have port imem_rdata (input, 16 bits), the instruction word; it is valid when imem_valid=1.
REQ-008 SHALL have port imem_valid (input, 1 bit), the fetch-complete strobe; it may arrive in the same cycle as imem_req or later.
REQ-009 SHALL have port current_instruction (output, 16 bits), the instruction register (IR).
REQ-010 SHALL have port program_counter_out (output, PC_W bits), the current PC.
REQ-011 SHALL have port results (output, DATA_W bits), the last EXECUTE result register.
REQ-012 SHALL have port zero_flag (output, 1 bit), set when the last ALU result was 0.
REQ-013 SHALL have port halted (output, 1 bit), high while in the HALT state.
REQ-014 SHALL have port retired (output, 16 bits), the count of completed instructions; it saturates at 0xFFFF.

Function
REQ-015 SHALL decode the instruction as: opcode [15:12], rd [11:9], rs1 [8:6], rs2 [5:3], imm8 [7:0]; the register file has 8 registers of DATA_W bits.
REQ-016 SHALL implement these opcodes:
- 0 NOP
- 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
- 6 SHL rs1 by 1, 7 SHR rs1 by 1 (logical)
- 8 LI: rd <= imm8, zero-extended or truncated to DATA_W
- 9 BEQZ: if rs1==0 then PC <= imm8[PC_W-1:0], zero-extended
- A JMP: PC <= imm8, zero-extended
- F HALT
- B..E execute as NOP
REQ-017 SHALL compute arithmetic modulo 2^DATA_W; carry and borrow are discarded.
REQ-018 SHALL sequence through the FSM states FETCH -> DECODE -> EXECUTE -> WRITEBACK -> FETCH, plus HALT.
REQ-019 In FETCH, SHALL drive imem_req=1 and hold there until imem_valid=1, then load IR from imem_rdata and advance to DECODE.
REQ-020 In DECODE, SHALL latch the rs1 and rs2 register contents into operand registers A and B.
REQ-021 In EXECUTE, SHALL update results for ALU ops and LI, update zero_flag for ALU ops only (opcodes 1-7), and evaluate the branch condition.
REQ-022 In WRITEBACK, SHALL write rd for ALU ops and LI, set PC to the target if taken, else PC+1, and increment retired.
REQ-023 SHALL wrap PC from 2^PC_W-1 to 0.
REQ-024 SHALL, on HALT in WRITEBACK, enter HALT with the PC unchanged and retired incremented; HALT is left only by rst.
REQ-025 In HALT, SHALL hold imem_req=0 and keep all registers frozen.
REQ-026 SHALL take exactly 4 cycles per instruction with zero-wait memory; each cycle imem_valid stays low in FETCH adds one cycle.
REQ-027 SHALL ignore imem_valid outside FETCH.
REQ-028 SHALL produce results and zero_flag unchanged by NOP, BEQZ, JMP, HALT and B..E.
REQ-029 SHALL, for an instruction with rd equal to rs1 or rs2, use the old value (operands are latched in DECODE).

Reset
REQ-030 When rst=1 at a clock edge, SHALL set state=FETCH, PC=0, IR=0, A=B=0, all 8 registers=0, results=0, zero_flag=0, halted=0, retired=0.
REQ-031 SHALL, on rst asserted mid-instruction including WRITEBACK, suppress that cycle's register-file write and PC update.
REQ-032 SHALL drive imem_req=1 in the first cycle after rst deasserts.

Structure
REQ-033 SHALL place opcode constants, the state encoding and field bit positions in shared package risc_fsm_pkg.
REQ-034 SHALL implement the register file as sub-module regfile_p:
- parameter DATA_W
- 8 entries
- 2 asynchronous read ports
- 1 synchronous write port with enable

Verification
REQ-035 Bench SHALL check: LI r1,5; LI r2,3; ADD r3,r1,r2 -> results=8, r3=8, retired=3, 12 cycles total with zero-wait memory.
REQ-036 Bench SHALL check, with DATA_W=8: LI r1,0xFF; LI r2,1; ADD r3,r1,r2 -> results=0x00, zero_flag=1; SUB r4,r0,r2 -> results=0xFF, zero_flag=0.
REQ-037 Bench SHALL check: BEQZ r0,0x20 -> PC=0x20; LI r1,1; BEQZ r1,0x40 -> PC advances to next sequential address; JMP from PC=0xFF with PC_W=8 and the fall-through case -> wrap to 0x00.
REQ-038 Bench SHALL check: imem_valid delayed 3 cycles on each fetch -> 7 cycles per instruction, IR and results identical to the zero-wait run.
REQ-039 Bench SHALL check: HALT -> halted=1 and imem_req=0 for 20 cycles, with PC and retired frozen; then rst pulse -> all outputs 0 and fetch from address 0.
REQ-040 Bench SHALL check: rst asserted in WRITEBACK of ADD r5 -> r5 stays 0 and retired=0.
